// File: rtl/cnn_pkg.sv
// Shared constants and helpers for the CNN requantization paths.
// Saturation limits, default widths and the per-group config bundle.
package cnn_pkg;

  localparam int ACC_W_D = 40;
  localparam int OUT_W_D = 8;

  localparam int INT8_MAX = 127;
  localparam int INT8_MIN = -128;

  localparam longint INT32_MAX = 64'sh0000_0000_7FFF_FFFF;
  localparam longint INT32_MIN = -64'sh0000_0000_8000_0000;

  typedef struct packed {
    logic signed [31:0] bias;
    logic [4:0]         shift;
    logic               relu_en;
  } rq_cfg_t;

  // Clamp a signed value to the range of an n-bit signed integer.
  function automatic longint sat_n(
    input longint v,
    input int     n
  );
    longint hi;
    longint lo;
    hi = (64'sd1 <<< (n - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi)
      return hi;
    else if (v < lo)
      return lo;
    else
      return v;
  endfunction

endpackage

// File: rtl/requant_round_sat.sv
// Result pipeline: bias add, rounding shift, ReLU and saturation.
// Two register stages; the valid travels alongside the data.
module requant_round_sat
  import cnn_pkg::*;
#(
  parameter int ACC_W = ACC_W_D,
  parameter int OUT_W = OUT_W_D
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_valid,
  input  logic signed [ACC_W-1:0] i_acc,
  input  rq_cfg_t                 i_cfg,
  output logic                    o_valid,
  output logic signed [OUT_W-1:0] o_dout,
  output logic signed [31:0]      o_psum,
  output logic                    o_sat
);

  // Two guard bits so bias and rounding can never wrap.
  localparam int EW = ACC_W + 2;

  logic signed [EW-1:0] w_s;
  logic [EW-1:0]        w_rnd;
  logic signed [EW-1:0] w_t;
  logic signed [EW-1:0] w_sh;

  logic signed [EW-1:0] r_s;
  logic signed [EW-1:0] r_sh;
  logic                 r_relu;
  logic                 r_v2;

  logic signed [63:0]   w_x;
  logic signed [63:0]   w_s64;
  logic signed [63:0]   w_q;
  logic signed [63:0]   w_p;
  logic                 w_sat;

  always_comb begin
    w_s = {{2{i_acc[ACC_W-1]}}, i_acc}
        + {{(EW-32){i_cfg.bias[31]}}, i_cfg.bias};
    w_rnd = '0;
    if (i_cfg.shift != 5'd0)
      w_rnd = EW'(1) << (i_cfg.shift - 5'd1);
    w_t  = w_s + signed'(w_rnd);
    w_sh = w_t >>> i_cfg.shift;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v2   <= 1'b0;
      r_s    <= '0;
      r_sh   <= '0;
      r_relu <= 1'b0;
    end else begin
      r_v2   <= i_valid;
      r_s    <= w_s;
      r_sh   <= w_sh;
      r_relu <= i_cfg.relu_en;
    end
  end

  always_comb begin
    w_x = {{(64-EW){r_sh[EW-1]}}, r_sh};
    if (r_relu && r_sh[EW-1])
      w_x = '0;
    w_s64 = {{(64-EW){r_s[EW-1]}}, r_s};
    w_q   = sat_n(w_x, OUT_W);
    w_p   = sat_n(w_s64, 32);
    w_sat = (w_q != w_x);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_dout  <= '0;
      o_psum  <= '0;
      o_sat   <= 1'b0;
    end else begin
      o_valid <= r_v2;
      if (r_v2) begin
        o_dout <= w_q[OUT_W-1:0];
        o_psum <= w_p[31:0];
        o_sat  <= w_sat;
      end
    end
  end

endmodule

// File: rtl/psum_requant.sv
// Partial-sum accumulator feeding the requantization pipeline.
// Counts NUM_TERMS valid terms per group, then hands off one result.
module psum_requant
  import cnn_pkg::*;
#(
  parameter int NUM_TERMS = 16,
  parameter int ACC_W     = ACC_W_D,
  parameter int OUT_W     = OUT_W_D
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ivalid,
  input  logic signed [31:0]      din,
  input  logic signed [31:0]      bias,
  input  logic [4:0]              shift,
  input  logic                    relu_en,
  output logic                    ovalid,
  output logic signed [OUT_W-1:0] dout,
  output logic signed [31:0]      psum,
  output logic                    sat
);

  localparam int CW = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_TERMS - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_ACC  = 1'b1;

  logic [0:0]              r_state;
  logic [CW-1:0]           r_cnt;
  logic signed [ACC_W-1:0] r_acc;
  rq_cfg_t                 r_cfg;
  logic signed [ACC_W-1:0] r_fin;
  rq_cfg_t                 r_fcfg;
  logic                    r_fv;

  logic signed [ACC_W-1:0] w_dx;
  logic signed [ACC_W-1:0] w_sum;
  rq_cfg_t                 w_cfg;
  logic                    w_last;

  always_comb begin
    w_dx   = {{(ACC_W-32){din[31]}}, din};
    w_sum  = r_acc + w_dx;
    w_cfg  = r_cfg;
    w_last = (r_cnt == LAST);
    // First term of a group starts fresh and latches the config.
    if (r_state == S_IDLE) begin
      w_sum = w_dx;
      w_cfg = '{bias: bias, shift: shift, relu_en: relu_en};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_cfg   <= '0;
      r_fin   <= '0;
      r_fcfg  <= '0;
      r_fv    <= 1'b0;
    end else begin
      r_fv <= 1'b0;
      if (ivalid) begin
        r_acc <= w_sum;
        r_cfg <= w_cfg;
        if (w_last) begin
          r_cnt   <= '0;
          r_state <= S_IDLE;
          r_fin   <= w_sum;
          r_fcfg  <= w_cfg;
          r_fv    <= 1'b1;
        end else begin
          r_cnt   <= r_cnt + CW'(1);
          r_state <= S_ACC;
        end
      end
    end
  end

  requant_round_sat #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W)
  ) u_rq (
    .clk     (clk),
    .rst     (rst),
    .i_valid (r_fv),
    .i_acc   (r_fin),
    .i_cfg   (r_fcfg),
    .o_valid (ovalid),
    .o_dout  (dout),
    .o_psum  (psum),
    .o_sat   (sat)
  );

endmodule

// File: tb/tb_psum_requant.sv
// Directed bench for psum_requant with NUM_TERMS = 4.
// Table of groups plus sequences for latency, gaps and reset.
module tb_psum_requant;

  logic               clk = 1'b0;
  logic               rst;
  logic               ivalid;
  logic signed [31:0] din;
  logic signed [31:0] bias;
  logic [4:0]         shift;
  logic               relu_en;
  logic               ovalid;
  logic signed [7:0]  dout;
  logic signed [31:0] psum;
  logic               sat;

  always #5 clk = ~clk;

  psum_requant #(.NUM_TERMS(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .ivalid  (ivalid),
    .din     (din),
    .bias    (bias),
    .shift   (shift),
    .relu_en (relu_en),
    .ovalid  (ovalid),
    .dout    (dout),
    .psum    (psum),
    .sat     (sat)
  );

  typedef struct {
    logic signed [7:0]  d;
    logic signed [31:0] p;
    logic               s;
  } res_t;

  typedef struct {
    logic signed [31:0] d [4];
    logic signed [31:0] b;
    logic [4:0]         sh;
    logic               r;
    longint             ed;
    longint             ep;
    longint             es;
  } vec_t;

  res_t q[$];
  int   checks   = 0;
  int   failures = 0;

  always @(negedge clk) begin
    res_t rr;
    if (ovalid === 1'b1) begin
      rr.d = dout;
      rr.p = psum;
      rr.s = sat;
      q.push_back(rr);
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic expect_res(input string nm, input longint ed,
                            input longint ep, input longint es);
    res_t rr;
    checks++;
    if (q.size() == 0) begin
      failures++;
      $display("FAIL %s: got no result expected one", nm);
    end else begin
      rr = q.pop_front();
      chk({nm, ".dout"}, rr.d, ed);
      chk({nm, ".psum"}, rr.p, ep);
      chk({nm, ".sat"}, longint'(rr.s), es);
    end
  endtask

  task automatic term(input logic signed [31:0] d);
    ivalid = 1'b1;
    din    = d;
    @(posedge clk);
    #1;
    ivalid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input longint d0, input longint d1,
                              input longint d2, input longint d3,
                              input longint b, input int sh, input int r,
                              input longint ed, input longint ep,
                              input longint es);
    vec_t v;
    v.d[0] = d0[31:0];
    v.d[1] = d1[31:0];
    v.d[2] = d2[31:0];
    v.d[3] = d3[31:0];
    v.b    = b[31:0];
    v.sh   = sh[4:0];
    v.r    = r[0];
    v.ed   = ed;
    v.ep   = ep;
    v.es   = es;
    return v;
  endfunction

  vec_t tv [16];

  initial begin
    tv[0]  = mk(1, 2, 3, 4, 0, 0, 0, 10, 10, 0);
    tv[1]  = mk(100, 100, 100, 100, -1000, 2, 1, 0, -600, 0);
    tv[2]  = mk(100, 100, 100, 100, -1000, 2, 0, -128, -600, 1);
    tv[3]  = mk(3, 0, 0, 0, 0, 1, 0, 2, 3, 0);
    tv[4]  = mk(-3, 0, 0, 0, 0, 1, 0, -1, -3, 0);
    tv[5]  = mk(64'h7FFFFFFF, 64'h7FFFFFFF, 64'h7FFFFFFF, 64'h7FFFFFFF,
                0, 0, 0, 127, 2147483647, 1);
    tv[6]  = mk(64'h80000000, 64'h80000000, 64'h80000000, 64'h80000000,
                0, 0, 0, -128, -64'sd2147483648, 1);
    tv[7]  = mk(64'h40000000, 64'h40000000, 64'h40000000, 64'h40000000,
                0, 31, 0, 2, 2147483647, 0);
    tv[8]  = mk(127, 0, 0, 0, 0, 0, 0, 127, 127, 0);
    tv[9]  = mk(128, 0, 0, 0, 0, 0, 0, 127, 128, 1);
    tv[10] = mk(-128, 0, 0, 0, 0, 0, 0, -128, -128, 0);
    tv[11] = mk(-129, 0, 0, 0, 0, 0, 0, -128, -129, 1);
    tv[12] = mk(10, 0, 0, 0, 5, 0, 0, 15, 15, 0);
    tv[13] = mk(5, 0, 0, 0, 0, 1, 0, 3, 5, 0);
    tv[14] = mk(-5, 0, 0, 0, 0, 1, 1, 0, -5, 0);
    tv[15] = mk(-100000, 0, 0, 0, 0, 0, 1, 0, -100000, 0);

    rst     = 1'b1;
    ivalid  = 1'b0;
    din     = '0;
    bias    = '0;
    shift   = '0;
    relu_en = 1'b0;
    idle(3);
    chk("rst.ovalid", longint'(ovalid), 0);
    chk("rst.dout", dout, 0);
    chk("rst.psum", psum, 0);
    chk("rst.sat", longint'(sat), 0);
    rst = 1'b0;
    idle(2);

    // Exact latency: last term sampled at edge E, ovalid in E+2..E+3.
    term(1);
    term(2);
    term(3);
    term(4);
    chk("lat.n1", longint'(ovalid), 0);
    idle(1);
    chk("lat.n2", longint'(ovalid), 0);
    idle(1);
    chk("lat.n3", longint'(ovalid), 1);
    chk("lat.dout", dout, 10);
    chk("lat.psum", psum, 10);
    chk("lat.sat", longint'(sat), 0);
    idle(1);
    chk("lat.n4", longint'(ovalid), 0);
    idle(2);
    q.delete();

    for (int i = 0; i < 16; i++) begin
      bias    = tv[i].b;
      shift   = tv[i].sh;
      relu_en = tv[i].r;
      for (int k = 0; k < 4; k++) term(tv[i].d[k]);
      idle(5);
      chk($sformatf("vec%0d.count", i), q.size(), 1);
      expect_res($sformatf("vec%0d", i), tv[i].ed, tv[i].ep, tv[i].es);
      q.delete();
    end

    // Back-to-back groups, mid-group config changes, then gapped group.
    bias    = 0;
    shift   = 0;
    relu_en = 1'b0;
    for (int k = 0; k < 4; k++) term(1);
    bias = 7;
    term(2);
    bias  = 100;
    shift = 4;
    term(2);
    term(2);
    term(2);
    shift = 0;
    for (int k = 1; k <= 4; k++) begin
      term(k);
      if (k == 1) begin
        shift   = 3;
        relu_en = 1'b1;
        bias    = -5000;
      end
      repeat ($urandom_range(0, 3)) idle(1);
    end
    idle(6);
    chk("b2b.count", q.size(), 3);
    expect_res("b2b.a", 4, 4, 0);
    expect_res("b2b.b", 15, 15, 0);
    expect_res("gap.c", 110, 110, 0);
    q.delete();

    // Reset after two terms; ivalid during reset is ignored.
    bias    = 0;
    shift   = 0;
    relu_en = 1'b0;
    term(9);
    term(9);
    rst    = 1'b1;
    ivalid = 1'b1;
    din    = 9;
    idle(1);
    rst    = 1'b0;
    ivalid = 1'b0;
    idle(3);
    chk("abort.none", q.size(), 0);
    for (int k = 0; k < 4; k++) term(5);
    idle(5);
    chk("abort.count", q.size(), 1);
    expect_res("abort.next", 20, 20, 0);
    q.delete();

    // Reset while a completed group is still in the result pipeline.
    for (int k = 0; k < 4; k++) term(1);
    idle(1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("drop.dout", dout, 0);
    chk("drop.psum", psum, 0);
    idle(5);
    chk("drop.none", q.size(), 0);
    for (int k = 0; k < 4; k++) term(-2);
    idle(5);
    chk("drop.count", q.size(), 1);
    expect_res("drop.next", -8, -8, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
